// File: rtl/qpu_exu_oitf_mq.sv
// Outstanding-instruction FIFO: records long-pipe rd/qubit owners at dispatch, frees in order at write-back.
// Latency: allocate/retire take effect on the next edge; hazard matches are combinational over registered entries. Backpressure: dis_ready low while full.
module qpu_exu_oitf_mq #(
    parameter int DEPTH     = 4,
    parameter int RFIDX_W   = 5,
    parameter int QUBIT_NUM = 8,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 dis_ena,
    output logic                 dis_ready,
    input  logic                 dis_rdwen,
    input  logic [RFIDX_W-1:0]   dis_rdidx,
    input  logic                 dis_qfren,
    input  logic [QUBIT_NUM-1:0] dis_qubitlist,
    output logic [PTR_W-1:0]     dis_ptr,
    input  logic                 ret_ena,
    output logic [PTR_W-1:0]     ret_ptr,
    output logic                 ret_rdwen,
    output logic [RFIDX_W-1:0]   ret_rdidx,
    output logic                 ret_qfren,
    output logic [QUBIT_NUM-1:0] ret_qubitlist,
    input  logic                 disp_rs1en,
    input  logic                 disp_rs2en,
    input  logic                 disp_rdwen,
    input  logic [RFIDX_W-1:0]   disp_rs1idx,
    input  logic [RFIDX_W-1:0]   disp_rs2idx,
    input  logic [RFIDX_W-1:0]   disp_rdidx,
    input  logic [QUBIT_NUM-1:0] disp_qubitlist,
    output logic                 oitfrd_match_disprs1,
    output logic                 oitfrd_match_disprs2,
    output logic                 oitfrd_match_disprd,
    output logic                 oitfqf_match_dispql,
    output logic                 oitf_empty,
    output logic [PTR_W:0]       oitf_count
);

    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0]                rdwen_q, rdwen_d;
    logic [DEPTH-1:0]                qfren_q, qfren_d;
    logic [DEPTH-1:0][RFIDX_W-1:0]   rdidx_q, rdidx_d;
    logic [DEPTH-1:0][QUBIT_NUM-1:0] qlist_q, qlist_d;

    logic             full, empty, alloc, retire;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             rs1_hit, rs2_hit, rd_hit, qf_hit;

    assign wr_idx = wr_ptr_q[PTR_W-1:0];
    assign rd_idx = rd_ptr_q[PTR_W-1:0];

    // Extra wrap bit distinguishes full from empty when the index bits coincide.
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign alloc  = dis_ena & ~full;
    assign retire = ret_ena & ~empty;

    assign dis_ready     = ~full;
    assign dis_ptr       = wr_idx;
    assign ret_ptr       = rd_idx;
    assign ret_rdwen     = rdwen_q[rd_idx];
    assign ret_rdidx     = rdidx_q[rd_idx];
    assign ret_qfren     = qfren_q[rd_idx];
    assign ret_qubitlist = qlist_q[rd_idx];
    assign oitf_empty    = empty;
    assign oitf_count    = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        rdwen_d  = rdwen_q;
        rdidx_d  = rdidx_q;
        qfren_d  = qfren_q;
        qlist_d  = qlist_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            valid_d  = '0;
        end else begin
            // Alloc and retire never target the same slot: alloc needs !full, retire needs !empty.
            if (alloc) begin
                valid_d[wr_idx] = 1'b1;
                rdwen_d[wr_idx] = dis_rdwen;
                rdidx_d[wr_idx] = dis_rdidx;
                qfren_d[wr_idx] = dis_qfren;
                qlist_d[wr_idx] = dis_qubitlist;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (retire) begin
                valid_d[rd_idx] = 1'b0;
                rd_ptr_d        = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
            rdwen_q  <= '0;
            rdidx_q  <= '0;
            qfren_q  <= '0;
            qlist_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            rdwen_q  <= rdwen_d;
            rdidx_q  <= rdidx_d;
            qfren_q  <= qfren_d;
            qlist_q  <= qlist_d;
        end
    end

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rd_hit  = 1'b0;
        qf_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rs1_hit = rs1_hit | (valid_q[i] & rdwen_q[i] & (rdidx_q[i] == disp_rs1idx));
            rs2_hit = rs2_hit | (valid_q[i] & rdwen_q[i] & (rdidx_q[i] == disp_rs2idx));
            rd_hit  = rd_hit  | (valid_q[i] & rdwen_q[i] & (rdidx_q[i] == disp_rdidx));
            qf_hit  = qf_hit  | (valid_q[i] & qfren_q[i] & (|(qlist_q[i] & disp_qubitlist)));
        end
    end

    assign oitfrd_match_disprs1 = disp_rs1en & rs1_hit;
    assign oitfrd_match_disprs2 = disp_rs2en & rs2_hit;
    assign oitfrd_match_disprd  = disp_rdwen & rd_hit;
    assign oitfqf_match_dispql  = qf_hit;

endmodule

// File: tb/tb_qpu_exu_oitf_mq.sv
// Bench for qpu_exu_oitf_mq: scoreboard of allocated entries, popped and compared against ret_* on retire.
module tb_qpu_exu_oitf_mq;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic       rdwen;
        logic [4:0] rdidx;
        logic       qfren;
        logic [7:0] ql;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst, flush, dis_ena, dis_ready, dis_rdwen, dis_qfren, ret_ena;
    logic [4:0] dis_rdidx, ret_rdidx, disp_rs1idx, disp_rs2idx, disp_rdidx;
    logic [7:0] dis_qubitlist, ret_qubitlist, disp_qubitlist;
    logic [1:0] dis_ptr, ret_ptr;
    logic       ret_rdwen, ret_qfren, disp_rs1en, disp_rs2en, disp_rdwen;
    logic       m_rs1, m_rs2, m_rd, m_qf, oitf_empty;
    logic [2:0] oitf_count;

    ent_t sb[$];
    ent_t exp_ret, obs_ret;
    int   mwr = 0, mrd = 0;
    int   checks = 0, passes = 0;

    always #5 clk = ~clk;

    qpu_exu_oitf_mq #(.DEPTH(DEPTH), .RFIDX_W(5), .QUBIT_NUM(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_rdwen(dis_rdwen), .dis_rdidx(dis_rdidx),
        .dis_qfren(dis_qfren), .dis_qubitlist(dis_qubitlist), .dis_ptr(dis_ptr),
        .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdwen(ret_rdwen), .ret_rdidx(ret_rdidx),
        .ret_qfren(ret_qfren), .ret_qubitlist(ret_qubitlist),
        .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rdwen(disp_rdwen),
        .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx), .disp_rdidx(disp_rdidx),
        .disp_qubitlist(disp_qubitlist),
        .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2), .oitfrd_match_disprd(m_rd),
        .oitfqf_match_dispql(m_qf), .oitf_empty(oitf_empty), .oitf_count(oitf_count)
    );

    task automatic clr_in();
        flush = 0; dis_ena = 0; dis_rdwen = 0; dis_rdidx = 0; dis_qfren = 0; dis_qubitlist = 0;
        ret_ena = 0; disp_rs1en = 0; disp_rs2en = 0; disp_rdwen = 0;
        disp_rs1idx = 0; disp_rs2idx = 0; disp_rdidx = 0; disp_qubitlist = 0;
    endtask

    // Updates the reference queue from the current controls, captures ret_* on a modelled retire, then clocks.
    task automatic clock_edge();
        int n;
        n = sb.size();
        if (flush) begin
            sb.delete(); mwr = 0; mrd = 0;
        end else begin
            if (ret_ena && n > 0) begin
                exp_ret = sb.pop_front();
                obs_ret = '{ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist};
                mrd = (mrd + 1) % DEPTH;
            end
            if (dis_ena && n < DEPTH) begin
                sb.push_back('{dis_rdwen, dis_rdidx, dis_qfren, dis_qubitlist});
                mwr = (mwr + 1) % DEPTH;
            end
        end
        @(posedge clk); #1;
        dis_ena = 0; ret_ena = 0; flush = 0;
    endtask

    task automatic test_reset();
        dis_rdwen = 1; dis_rdidx = 5; dis_qfren = 1; dis_qubitlist = 8'hFF;
        dis_ena = 1; clock_edge();
        dis_ena = 1; clock_edge();
        disp_rs1en = 1; disp_rs2en = 1; disp_rdwen = 1;
        disp_rs1idx = 5; disp_rs2idx = 5; disp_rdidx = 5; disp_qubitlist = 8'hFF;
        #1;
        checks++; if (oitf_count !== 3'(sb.size())) $display("FAIL rst_pre_count got=%0d exp=%0d", oitf_count, sb.size()); else passes++;
        checks++; if (m_rs1 !== 1'b1) $display("FAIL rst_pre_rs1 got=%b exp=1", m_rs1); else passes++;
        #2 rst = 1;
        #1;
        sb.delete(); mwr = 0; mrd = 0;
        checks++; if (dis_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", dis_ready); else passes++;
        checks++; if (oitf_empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", oitf_empty); else passes++;
        checks++; if (oitf_count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", oitf_count); else passes++;
        checks++; if ({m_rs1, m_rs2, m_rd, m_qf} !== 4'b0) $display("FAIL rst_matches got=%b exp=0000", {m_rs1, m_rs2, m_rd, m_qf}); else passes++;
        checks++; if ({dis_ptr, ret_ptr} !== 4'b0) $display("FAIL rst_ptrs got=%b exp=0000", {dis_ptr, ret_ptr}); else passes++;
        checks++; if ({ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist} !== 15'b0) $display("FAIL rst_ret got=%h exp=0", {ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist}); else passes++;
        @(posedge clk); #1 rst = 0;
        clr_in();
    endtask

    task automatic test_fill();
        dis_rdwen = 1;
        for (int k = 0; k < 4; k++) begin
            dis_rdidx = 5'(3 + 2 * k); dis_ena = 1; #1;
            checks++; if (dis_ptr !== 2'(mwr)) $display("FAIL fill_dis_ptr got=%0d exp=%0d", dis_ptr, mwr); else passes++;
            clock_edge();
        end
        checks++; if (oitf_count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", oitf_count); else passes++;
        checks++; if (dis_ready !== 1'b0) $display("FAIL fill_ready got=%b exp=0", dis_ready); else passes++;
        checks++; if (dis_ptr !== 2'd0) $display("FAIL fill_ptr_wrap got=%0d exp=0", dis_ptr); else passes++;
        dis_rdidx = 11; dis_ena = 1; clock_edge();
        checks++; if (oitf_count !== 3'd4) $display("FAIL fill_over_count got=%0d exp=4", oitf_count); else passes++;
        for (int k = 0; k < 4; k++) begin
            ret_ena = 1; #1;
            checks++; if (ret_ptr !== 2'(mrd)) $display("FAIL fill_ret_ptr got=%0d exp=%0d", ret_ptr, mrd); else passes++;
            clock_edge();
            checks++; if (obs_ret.rdidx !== exp_ret.rdidx) $display("FAIL fill_ret_rdidx got=%0d exp=%0d", obs_ret.rdidx, exp_ret.rdidx); else passes++;
        end
        checks++; if (oitf_empty !== 1'b1) $display("FAIL fill_drained got=%b exp=1", oitf_empty); else passes++;
        clr_in();
    endtask

    task automatic test_hazard();
        dis_rdwen = 1; dis_rdidx = 5; dis_ena = 1;
        disp_rs1en = 1; disp_rs1idx = 5; #1;
        checks++; if (m_rs1 !== 1'b0) $display("FAIL haz_same_cycle got=%b exp=0", m_rs1); else passes++;
        clock_edge();
        checks++; if (m_rs1 !== 1'b1) $display("FAIL haz_rs1 got=%b exp=1", m_rs1); else passes++;
        disp_rs1en = 0; #1;
        checks++; if (m_rs1 !== 1'b0) $display("FAIL haz_rs1en0 got=%b exp=0", m_rs1); else passes++;
        disp_rs2en = 1; disp_rs2idx = 5; #1;
        checks++; if (m_rs2 !== 1'b1) $display("FAIL haz_rs2 got=%b exp=1", m_rs2); else passes++;
        disp_rs2idx = 6; #1;
        checks++; if (m_rs2 !== 1'b0) $display("FAIL haz_rs2_miss got=%b exp=0", m_rs2); else passes++;
        disp_rdwen = 1; disp_rdidx = 5; ret_ena = 1; #1;
        checks++; if (m_rd !== 1'b1) $display("FAIL haz_rd_retiring got=%b exp=1", m_rd); else passes++;
        clock_edge();
        checks++; if (obs_ret !== exp_ret) $display("FAIL haz_ret got=%h exp=%h", obs_ret, exp_ret); else passes++;
        checks++; if (m_rd !== 1'b0) $display("FAIL haz_rd_retired got=%b exp=0", m_rd); else passes++;
        dis_rdwen = 0; dis_rdidx = 5; dis_ena = 1; clock_edge();
        disp_rs1en = 1; disp_rs1idx = 5; #1;
        checks++; if ({m_rs1, m_rd} !== 2'b00) $display("FAIL haz_nordwen got=%b exp=00", {m_rs1, m_rd}); else passes++;
        ret_ena = 1; clock_edge();
        clr_in();
    endtask

    task automatic test_qubit();
        dis_qfren = 1; dis_qubitlist = 8'b0000_0110; dis_ena = 1; clock_edge();
        disp_qubitlist = 8'b0000_0100; #1;
        checks++; if (m_qf !== 1'b1) $display("FAIL qf_overlap got=%b exp=1", m_qf); else passes++;
        disp_qubitlist = 8'b1000_0000; #1;
        checks++; if (m_qf !== 1'b0) $display("FAIL qf_disjoint got=%b exp=0", m_qf); else passes++;
        disp_qubitlist = 8'b0000_0100; ret_ena = 1; #1;
        checks++; if (m_qf !== 1'b1) $display("FAIL qf_retiring got=%b exp=1", m_qf); else passes++;
        clock_edge();
        checks++; if (obs_ret !== exp_ret) $display("FAIL qf_ret got=%h exp=%h", obs_ret, exp_ret); else passes++;
        checks++; if (m_qf !== 1'b0) $display("FAIL qf_retired got=%b exp=0", m_qf); else passes++;
        dis_qfren = 0; dis_qubitlist = 8'b0000_0110; dis_ena = 1; clock_edge();
        #1;
        checks++; if (m_qf !== 1'b0) $display("FAIL qf_noqfren got=%b exp=0", m_qf); else passes++;
        ret_ena = 1; clock_edge();
        clr_in();
    endtask

    task automatic test_full_simul();
        dis_rdwen = 1;
        for (int k = 0; k < 4; k++) begin
            dis_rdidx = 5'(k + 1); dis_qubitlist = 8'(k * 3); dis_ena = 1; clock_edge();
        end
        dis_rdidx = 20; dis_ena = 1; ret_ena = 1; #1;
        checks++; if (dis_ready !== 1'b0) $display("FAIL simul_ready got=%b exp=0", dis_ready); else passes++;
        clock_edge();
        checks++; if (oitf_count !== 3'd3) $display("FAIL simul_count3 got=%0d exp=3", oitf_count); else passes++;
        checks++; if (obs_ret !== exp_ret) $display("FAIL simul_ret got=%h exp=%h", obs_ret, exp_ret); else passes++;
        dis_ena = 1; #1;
        checks++; if (dis_ready !== 1'b1) $display("FAIL simul_ready_next got=%b exp=1", dis_ready); else passes++;
        clock_edge();
        checks++; if (oitf_count !== 3'd4) $display("FAIL simul_count4 got=%0d exp=4", oitf_count); else passes++;
        for (int k = 0; k < 4; k++) begin
            ret_ena = 1; clock_edge();
            checks++; if (obs_ret !== exp_ret) $display("FAIL simul_drain got=%h exp=%h", obs_ret, exp_ret); else passes++;
        end
        ret_ena = 1; clock_edge();
        checks++; if ({oitf_empty, oitf_count} !== 4'b1000) $display("FAIL empty_ret got=%b exp=1000", {oitf_empty, oitf_count}); else passes++;
        checks++; if (ret_ptr !== 2'(mrd)) $display("FAIL empty_ret_ptr got=%0d exp=%0d", ret_ptr, mrd); else passes++;
        clr_in();
    endtask

    task automatic test_flush();
        dis_rdwen = 1; dis_qfren = 1; dis_qubitlist = 8'h0F;
        for (int k = 0; k < 3; k++) begin
            dis_rdidx = 5'(8 + k); dis_ena = 1; clock_edge();
        end
        dis_ena = 1; ret_ena = 1; flush = 1; clock_edge();
        disp_rs1en = 1; disp_rs2en = 1; disp_rdwen = 1;
        disp_rs1idx = 8; disp_rs2idx = 9; disp_rdidx = 10; disp_qubitlist = 8'h0F; #1;
        checks++; if ({oitf_empty, oitf_count} !== 4'b1000) $display("FAIL flush_empty got=%b exp=1000", {oitf_empty, oitf_count}); else passes++;
        checks++; if ({dis_ptr, ret_ptr} !== 4'b0) $display("FAIL flush_ptrs got=%b exp=0000", {dis_ptr, ret_ptr}); else passes++;
        checks++; if ({m_rs1, m_rs2, m_rd, m_qf} !== 4'b0) $display("FAIL flush_matches got=%b exp=0000", {m_rs1, m_rs2, m_rd, m_qf}); else passes++;
        dis_rdidx = 12; dis_qubitlist = 8'h30; dis_ena = 1; clock_edge();
        ret_ena = 1; clock_edge();
        checks++; if (obs_ret !== exp_ret) $display("FAIL flush_after got=%h exp=%h", obs_ret, exp_ret); else passes++;
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_fill();
        test_hazard();
        test_qubit();
        test_full_simul();
        test_flush();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
